// File: rtl/axi_adder_seq_pkg.sv
// Shared types and constants for the axi_adder job sequencer.
package axi_adder_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RD,
        RR,
        DONE
    } state_e;

    localparam logic [31:0] REG_A   = 32'h0000_0000;
    localparam logic [31:0] REG_B   = 32'h0000_0004;
    localparam logic [31:0] REG_SUM = 32'h0000_0008;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_adder_job_sequencer_if.sv
// AXI4-Lite bus between the job sequencer (master) and the axi_adder slave.
interface axi_adder_job_sequencer_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   m_awaddr;
    logic [2:0]                m_awprot;
    logic                      m_awvalid;
    logic                      m_awready;
    logic [C_DATA_WIDTH-1:0]   m_wdata;
    logic [C_DATA_WIDTH/8-1:0] m_wstrb;
    logic                      m_wvalid;
    logic                      m_wready;
    logic [1:0]                m_bresp;
    logic                      m_bvalid;
    logic                      m_bready;
    logic [C_ADDR_WIDTH-1:0]   m_araddr;
    logic [2:0]                m_arprot;
    logic                      m_arvalid;
    logic                      m_arready;
    logic [C_DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]                m_rresp;
    logic                      m_rvalid;
    logic                      m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arprot, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awprot, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arprot, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );

endinterface

// File: rtl/axi_adder_seq_timeout.sv
// Per-phase watchdog: counts cycles spent in a bus phase, flags expiry at C_TIMEOUT.
module axi_adder_seq_timeout #(
    parameter int C_TIMEOUT = 255
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(C_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q is the number of earlier cycles in this phase, so the C_TIMEOUT-th cycle expires
    assign expired = en && (cnt_q >= CW'(C_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !expired)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/axi_adder_job_sequencer.sv
// Turns each (A, B) job into write A, write B, read sum on the axi_adder AXI4-Lite slave.
module axi_adder_job_sequencer
    import axi_adder_seq_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH = 32,
    parameter int                      C_DATA_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0,
    parameter int                      C_TIMEOUT    = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [C_DATA_WIDTH-1:0] job_a,
    input  logic [C_DATA_WIDTH-1:0] job_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [C_DATA_WIDTH-1:0] res_data,
    output logic                    res_err,
    output logic                    busy,
    axi_adder_job_sequencer_if.master m_axi
);
    state_e                  state_q, state_d;
    logic                    is_b_q, is_b_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [C_DATA_WIDTH-1:0] b_q, b_d;
    logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [C_DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                    res_err_q, res_err_d;

    logic awvalid, wvalid, bready, arvalid, rready;
    logic aw_hs, w_hs;
    logic tmo_clr, tmo_en, tmo_expired;

    axi_adder_seq_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_timeout (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign tmo_en  = state_q inside {WR, WB, RD, RR};
    assign tmo_clr = (state_d != state_q);
    assign aw_hs   = awvalid && m_axi.m_awready;
    assign w_hs    = wvalid && m_axi.m_wready;

    always_comb begin
        state_d    = state_q;
        is_b_d     = is_b_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        b_d        = b_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        job_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;

        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) begin
                    b_d       = job_b;
                    is_b_d    = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = C_BASE_ADDR + C_ADDR_WIDTH'(REG_A);
                    wdata_d   = job_a;
                    res_err_d = 1'b0;
                    state_d   = WR;
                end
            end
            WR: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d)
                    state_d = WB;
                else if (tmo_expired)
                    state_d = DONE;
            end
            WB: begin
                bready = 1'b1;
                if (m_axi.m_bvalid) begin
                    if (m_axi.m_bresp != OKAY) begin
                        state_d = DONE;
                    end else if (!is_b_q) begin
                        is_b_d    = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awaddr_d  = C_BASE_ADDR + C_ADDR_WIDTH'(REG_B);
                        wdata_d   = b_q;
                        state_d   = WR;
                    end else begin
                        araddr_d = C_BASE_ADDR + C_ADDR_WIDTH'(REG_SUM);
                        state_d  = RD;
                    end
                end else if (tmo_expired) begin
                    state_d = DONE;
                end
            end
            RD: begin
                arvalid = 1'b1;
                if (m_axi.m_arready)
                    state_d = RR;
                else if (tmo_expired)
                    state_d = DONE;
            end
            RR: begin
                rready = 1'b1;
                if (m_axi.m_rvalid) begin
                    res_data_d = m_axi.m_rdata;
                    res_err_d  = (m_axi.m_rresp != OKAY);
                    state_d    = DONE;
                end else if (tmo_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every path into DONE other than a clean R beat is an error: zero the result
        if (state_q != DONE && state_d == DONE && !(state_q == RR && m_axi.m_rvalid)) begin
            res_err_d  = 1'b1;
            res_data_d = '0;
        end else if (state_q == RR && state_d == DONE && res_err_d) begin
            res_data_d = '0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            is_b_q     <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            b_q        <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_b_q     <= is_b_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            b_q        <= b_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    assign res_data        = res_data_q;
    assign res_err         = res_err_q;
    assign m_axi.m_awaddr  = awaddr_q;
    assign m_axi.m_awprot  = 3'b000;
    assign m_axi.m_awvalid = awvalid;
    assign m_axi.m_wdata   = wdata_q;
    assign m_axi.m_wstrb   = '1;
    assign m_axi.m_wvalid  = wvalid;
    assign m_axi.m_bready  = bready;
    assign m_axi.m_araddr  = araddr_q;
    assign m_axi.m_arprot  = 3'b000;
    assign m_axi.m_arvalid = arvalid;
    assign m_axi.m_rready  = rready;

endmodule

// File: tb/tb_axi_adder_job_sequencer.sv
// Directed + randomized bench: a behavioural AXI4-Lite adder slave and a job-level result model.
module tb_axi_adder_job_sequencer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          TMO  = 8;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_a = '0, job_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;

    axi_adder_job_sequencer_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) bus ();

    axi_adder_job_sequencer #(
        .C_ADDR_WIDTH(32), .C_DATA_WIDTH(32), .C_BASE_ADDR(BASE), .C_TIMEOUT(TMO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy), .m_axi(bus)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave (acts on negedges) ----------------
    int  aw_dly = 0, w_dly = 0, ar_dly = 0;
    int  b_err_off = -1;
    bit  r_err = 0, ar_hang = 0;
    int  aw_wait, w_wait, ar_wait;
    bit  aw_got, w_got, b_pend, b_drop, r_pend, r_drop;
    logic [31:0] aw_addr, w_data;
    logic [31:0] sreg [4];
    int  w_only, ar_hi;
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];

    initial begin
        bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0;
        bus.m_bvalid = 0; bus.m_bresp = 0; bus.m_rvalid = 0; bus.m_rresp = 0; bus.m_rdata = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0;
                bus.m_bvalid = 0; bus.m_rvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                aw_got = 0; w_got = 0; b_pend = 0; b_drop = 0; r_pend = 0; r_drop = 0;
            end else begin
                if (b_drop) begin bus.m_bvalid = 0; b_drop = 0; end
                if (b_pend) begin
                    bus.m_bvalid = 1;
                    bus.m_bresp  = (int'(aw_addr - BASE) == b_err_off) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end
                if (bus.m_bvalid && bus.m_bready) b_drop = 1;

                if (r_drop) begin bus.m_rvalid = 0; r_drop = 0; end
                if (r_pend) begin
                    bus.m_rvalid = 1;
                    bus.m_rdata  = sreg[0] + sreg[1];
                    bus.m_rresp  = r_err ? 2'b10 : 2'b00;
                    r_pend = 0;
                end
                if (bus.m_rvalid && bus.m_rready) r_drop = 1;

                if (bus.m_wvalid && !bus.m_awvalid) w_only++;
                bus.m_awready = bus.m_awvalid && (aw_wait >= aw_dly);
                if (bus.m_awvalid && !bus.m_awready) aw_wait++;
                if (bus.m_awvalid && bus.m_awready) begin aw_wait = 0; aw_got = 1; aw_addr = bus.m_awaddr; end
                bus.m_wready = bus.m_wvalid && (w_wait >= w_dly);
                if (bus.m_wvalid && !bus.m_wready) w_wait++;
                if (bus.m_wvalid && bus.m_wready) begin w_wait = 0; w_got = 1; w_data = bus.m_wdata; end
                if (aw_got && w_got) begin
                    wr_addr_q.push_back(aw_addr);
                    wr_data_q.push_back(w_data);
                    if (((aw_addr - BASE) >> 2) < 4) sreg[2'((aw_addr - BASE) >> 2)] = w_data;
                    aw_got = 0; w_got = 0; b_pend = 1;
                end

                if (bus.m_arvalid) ar_hi++;
                bus.m_arready = bus.m_arvalid && !ar_hang && (ar_wait >= ar_dly);
                if (bus.m_arvalid && !bus.m_arready) ar_wait++;
                if (bus.m_arvalid && bus.m_arready) begin
                    ar_wait = 0; rd_addr_q.push_back(bus.m_araddr); r_pend = 1;
                end
            end
        end
    end

    // ---------------- job-level reference ----------------
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input bit err);
        return err ? 33'h1_0000_0000 : {1'b0, a + b};
    endfunction

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int hold,
                           output int lat, output logic [31:0] d, output logic e, output int hold_ok);
        int n, t0;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        w_only = 0; ar_hi = 0; hold_ok = 0;
        @(negedge ACLK);
        job_valid = 1; job_a = a; job_b = b;
        n = 0;
        while (!job_ready && n < 200) begin @(negedge ACLK); n++; end
        check("job_accept", job_ready, 1);
        t0 = cyc;
        @(negedge ACLK);
        job_valid = 0;
        n = 0;
        while (!res_valid && n < 300) begin @(negedge ACLK); n++; end
        check("res_valid_seen", res_valid, 1);
        lat = cyc - t0; d = res_data; e = res_err;
        repeat (hold) begin
            if (res_valid && busy) hold_ok++;
            @(negedge ACLK);
        end
        res_ready = 1;
        @(negedge ACLK);
        res_ready = 0;
    endtask

    task automatic check_bus(input int nw, input logic [31:0] a, input logic [31:0] b, input int nr);
        check("wr_count", wr_addr_q.size(), nw);
        for (int i = 0; i < nw; i++) begin
            if (i < wr_addr_q.size()) begin
                check("wr_addr", wr_addr_q[i], BASE + 32'(4 * i));
                check("wr_data", wr_data_q[i], (i == 0) ? a : b);
            end
        end
        check("rd_count", rd_addr_q.size(), nr);
        if (nr > 0 && rd_addr_q.size() > 0) check("rd_addr", rd_addr_q[0], BASE + 32'h8);
    endtask

    int          lat, hold_ok, n;
    logic [31:0] d, ra, rb;
    logic        e;
    logic [32:0] exp_r;
    int          m;

    initial begin
        // reset state
        repeat (3) @(negedge ACLK);
        check("rst_job_ready", job_ready, 1);
        check("rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready, res_valid}, 0);
        check("rst_busy", busy, 0);
        check("rst_res", {res_err, res_data}, 0);
        check("rst_addr", {bus.m_awaddr, bus.m_wdata, bus.m_araddr}, 0);
        ARESET = 0;
        @(negedge ACLK);

        // zero-wait 3 + 4
        run_job(32'h3, 32'h4, 0, lat, d, e, hold_ok);
        exp_r = model(32'h3, 32'h4, 0);
        check("basic_lat", lat, 7);
        check("basic_res", {e, d}, exp_r);
        check_bus(2, 32'h3, 32'h4, 1);

        // wready lags awready by 3
        w_dly = 3;
        run_job(32'd10, 32'd20, 0, lat, d, e, hold_ok);
        check("wdly_res", {e, d}, model(32'd10, 32'd20, 0));
        check("wdly_w_only", w_only, 6);
        check("wdly_lat", lat, 13);
        check_bus(2, 32'd10, 32'd20, 1);
        w_dly = 0;

        // overflow wraps
        run_job(32'hFFFF_FFFF, 32'h2, 0, lat, d, e, hold_ok);
        check("ovf_res", {e, d}, 33'h0_0000_0001);

        // SLVERR on write of B, then a clean job
        b_err_off = 4;
        run_job(32'h11, 32'h22, 0, lat, d, e, hold_ok);
        check("berr_res", {e, d}, model(32'h11, 32'h22, 1));
        check("berr_lat", lat, 5);
        check_bus(2, 32'h11, 32'h22, 0);
        b_err_off = -1;
        run_job(32'h5, 32'h6, 0, lat, d, e, hold_ok);
        check("after_err_res", {e, d}, model(32'h5, 32'h6, 0));

        // SLVERR on write of A skips write B
        b_err_off = 0;
        run_job(32'h7, 32'h8, 0, lat, d, e, hold_ok);
        check("aerr_res", {e, d}, model(32'h7, 32'h8, 1));
        check_bus(1, 32'h7, 32'h8, 0);
        b_err_off = -1;

        // SLVERR on read
        r_err = 1;
        run_job(32'h9, 32'h1, 0, lat, d, e, hold_ok);
        check("rerr_res", {e, d}, model(32'h9, 32'h1, 1));
        r_err = 0;

        // arready stuck low: timeout after TMO cycles of arvalid
        ar_hang = 1;
        run_job(32'h12, 32'h34, 0, lat, d, e, hold_ok);
        check("tmo_res", {e, d}, model(32'h12, 32'h34, 1));
        check("tmo_ar_cycles", ar_hi, TMO);
        check("tmo_lat", lat, 4 + TMO + 1);
        check_bus(2, 32'h12, 32'h34, 0);
        ar_hang = 0;

        // result held while res_ready stays low
        run_job(32'h100, 32'h200, 4, lat, d, e, hold_ok);
        check("hold_cycles", hold_ok, 4);
        check("hold_res", {e, d}, model(32'h100, 32'h200, 0));

        // asynchronous reset while in WB
        @(negedge ACLK);
        job_valid = 1; job_a = 32'hA; job_b = 32'hB;
        @(negedge ACLK);
        job_valid = 0;
        n = 0;
        while (!bus.m_bready && n < 50) begin @(negedge ACLK); n++; end
        check("wb_reached", bus.m_bready, 1);
        ARESET = 1;
        #1;
        check("arst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready, res_valid}, 0);
        check("arst_job_ready", job_ready, 1);
        check("arst_busy", busy, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        check("post_rst_ready", job_ready, 1);
        run_job(32'h21, 32'h13, 0, lat, d, e, hold_ok);
        check("post_rst_res", {e, d}, model(32'h21, 32'h13, 0));

        // randomized jobs with random slave wait states
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            m = (aw_dly > w_dly) ? aw_dly : w_dly;
            run_job(ra, rb, $urandom_range(0, 2), lat, d, e, hold_ok);
            check("rnd_res", {e, d}, model(ra, rb, 0));
            check("rnd_lat", lat, 2 * m + ar_dly + 7);
            check_bus(2, ra, rb, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
